// File: rtl/seg_pattern_reader.sv
// Decodes active-low 7-segment patterns into hex nibbles and packs DIGITS of them per word.
// Optional macro SEG_PATTERN_READER_BLANK_EN: pattern 7F (blank) decodes to 0 without flagging err.
module seg_pattern_reader #(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [6:0]            seg_in,
  input  logic                  seg_valid,
  output logic                  seg_ready,
  output logic [4*DIGITS-1:0]   word_out,
  output logic                  word_valid,
  input  logic                  word_ready,
  output logic                  err,
  output logic [2:0]            count
);

  typedef enum logic {COLLECT, FULL} state_t;

  localparam logic [3:0] LAST = 4'(DIGITS - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [4:0] dec;

  // Returns {unrecognised, nibble}.
  function automatic logic [4:0] decode(input logic [6:0] p);
    case (p)
      7'h40: decode = 5'h00;
      7'h79: decode = 5'h01;
      7'h24: decode = 5'h02;
      7'h30: decode = 5'h03;
      7'h19: decode = 5'h04;
      7'h12: decode = 5'h05;
      7'h02: decode = 5'h06;
      7'h78: decode = 5'h07;
      7'h00: decode = 5'h08;
      7'h18: decode = 5'h09;
      7'h08: decode = 5'h0A;
      7'h03: decode = 5'h0B;
      7'h46: decode = 5'h0C;
      7'h21: decode = 5'h0D;
      7'h06: decode = 5'h0E;
      7'h0E: decode = 5'h0F;
`ifdef SEG_PATTERN_READER_BLANK_EN
      7'h7F: decode = 5'h00;
`else
      7'h7F: decode = 5'h10;
`endif
      default: decode = 5'h10;
    endcase
  endfunction

  assign dec = decode(seg_in);

  // The 3-bit port cannot show 8; it reads 7 once an 8-digit word is full.
  assign count = (cnt > 4'd7) ? 3'd7 : cnt[2:0];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= COLLECT;
      word_out   <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      word_valid <= 1'b0;
      seg_ready  <= 1'b1;
    end else begin
      case (state)
        COLLECT: begin
          if (seg_valid) begin
            word_out <= {word_out[4*DIGITS-5:0], dec[3:0]};
            cnt      <= cnt + 4'd1;
            err      <= err | dec[4];
            if (cnt == LAST) begin
              state      <= FULL;
              seg_ready  <= 1'b0;
              word_valid <= 1'b1;
            end
          end
        end
        FULL: begin
          if (word_ready) begin
            state      <= COLLECT;
            word_out   <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            word_valid <= 1'b0;
            seg_ready  <= 1'b1;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

endmodule

// File: doc/seg_pattern_reader.md
SEG_PATTERN_READER -- requirements
Module: seg_pattern_reader

Interface
REQ-001 Parameter: DIGITS, default 4, number of digit patterns assembled per output word (legal range 2..8).
REQ-002 Port: clock  in  1  rising-edge clock for all state.
REQ-003 Port: reset  in  1  asynchronous, active-high reset.
REQ-004 Port: seg_in  in  7  active-low segment pattern, bit0 = segment a … bit6 = segment g.
REQ-005 Port: seg_valid  in  1  seg_in holds a pattern this cycle.
REQ-006 Port: seg_ready  out  1  block accepts a pattern this cycle.
REQ-007 Port: word_out  out  4*DIGITS  assembled hex digits, first-received digit in the most significant nibble.
REQ-008 Port: word_valid  out  1  word_out is complete and stable.
REQ-009 Port: word_ready  in  1  consumer takes word_out this cycle.
REQ-010 Port: err  out  1  at least one pattern in the current word was not recognised.
REQ-011 Port: count  out  3  number of digits accepted into the current word.

Function
REQ-012 Decode table (seg_in to nibble): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F (all hex).
REQ-013 Any other pattern is unrecognised: its nibble is stored as 0 and err is set.
REQ-014 A pattern is accepted on a rising edge where seg_valid and seg_ready are both 1; no other edge changes word_out or count.
REQ-015 State machine: COLLECT (seg_ready=1, word_valid=0) and FULL (seg_ready=0, word_valid=1).
REQ-016 In COLLECT, each acceptance shifts the decoded nibble into the least significant nibble of word_out and increments count.
REQ-017 When the DIGITS-th acceptance occurs, the next state is FULL; word_valid is asserted the cycle after that acceptance (latency of 1 cycle).
REQ-018 In FULL, word_out, err and count are held; seg_valid is ignored.
REQ-019 In FULL with word_ready=1: on that edge, go to COLLECT, clear word_out, count and err; seg_ready returns to 1 on the following cycle.
REQ-020 word_ready while in COLLECT has no effect.
REQ-021 err is sticky within a word and clears only on word hand-off or reset.
REQ-022 count saturates at DIGITS and never wraps.
REQ-023 seg_ready is a pure function of state (no combinational path from seg_valid or word_ready).

Reset
REQ-024 reset=1 forces, asynchronously, state=COLLECT, word_out=0, count=0, err=0, word_valid=0, seg_ready=1.
REQ-025 Reset asserted mid-word or in FULL discards the partial or pending word with no output.
REQ-026 Deassertion of reset takes effect at the next rising clock edge; the first acceptance can occur on that edge.

Configuration
REQ-027 Macro SEG_PATTERN_READER_BLANK_EN: when defined, pattern 7F (all segments off) decodes to nibble 0 without setting err.
REQ-028 Without SEG_PATTERN_READER_BLANK_EN, pattern 7F is unrecognised per REQ-013.

Verification
REQ-029 DIGITS=4; feed 79,24,30,19 back-to-back with word_ready=0 -> word_valid=1 one cycle after the 4th acceptance, word_out=16'h1234, err=0, seg_ready=0.
REQ-030 Feed all 16 legal patterns as four words -> words 0123, 4567, 89AB, CDEF, each with err=0.
REQ-031 Feed 40,55,40,40 -> word_out=16'h0000, err=1; next word 79,79,79,79 -> word_out=16'h1111, err=0.
REQ-032 Word full with word_ready held 0 for 10 cycles while seg_valid=1 with varying seg_in -> word_out unchanged, count=4; then word_ready=1 for 1 cycle -> word_valid=0 and count=0 on the next cycle.
REQ-033 Accept 2 digits, then pulse reset between clock edges -> all outputs reach reset values immediately; the next 4 digits 06,0E,08,03 give word_out=16'hEFAB.
REQ-034 Feed 7F,79,7F,79 -> with the macro: word_out=16'h0101, err=0; without the macro: word_out=16'h0101, err=1.
